// File: rtl/uart_send.sv
// UART 8N1 byte transmitter: a small byte FIFO feeds a serialiser that sends
// frames LSB first on dout, back-to-back while bytes are queued.
module uart_send #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       dout,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic cnt_last;

  assign cnt_last = (cnt == CW'(DIV - 1));
  assign ready    = (count != (AW + 1)'(FIFO_DEPTH));
  assign push     = valid && ready;
  // The head is taken from IDLE, or on the last stop-bit cycle so the next
  // start bit follows with no idle gap.
  assign pop      = (count != '0) &&
                    ((state == IDLE) || ((state == STOP) && cnt_last));
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      dout  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          dout <= 1'b1;
          cnt  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            dout  <= 1'b0;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
            dout  <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              dout  <= 1'b1;
            end else begin
              idx  <= idx + 3'd1;
              dout <= shift[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              dout  <= 1'b0;
            end else begin
              state <= IDLE;
              dout  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          dout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send at DIV=16: a line monitor decodes frames from dout and
// compares them against a queue of bytes accepted by the handshake.
module tb_uart_send;

  localparam int unsigned DIV   = 16;
  localparam int unsigned FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = '0;
  logic       ready;
  logic       dout;
  logic       busy;

  uart_send #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (data),
    .ready (ready),
    .dout  (dout),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [7:0]  sb[$];
  int unsigned starts[$];
  int unsigned frames = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Line monitor: samples every cycle of a frame and flags any cell that
  // changes within its DIV cycles.
  logic        in_frame = 1'b0;
  int unsigned samp = 0;
  int unsigned glitch = 0;
  logic [9:0]  fbits;
  logic        cellval;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (dout == 1'b0) begin
        in_frame = 1'b1;
        samp     = 1;
        glitch   = 0;
        fbits    = '0;
        cellval  = 1'b0;
        starts.push_back(cyc);
      end
    end else begin
      if (samp % DIV == 0) begin
        cellval = dout;
        fbits[samp / DIV] = dout;
      end else if (dout !== cellval) begin
        glitch++;
      end
      samp++;
      if (samp == FRAME) begin
        in_frame = 1'b0;
        frames++;
        chk("cell_stable", glitch, 0);
        chk("stop_bit", {31'd0, fbits[9]}, 1);
        if (sb.size() == 0) chk("unexpected_frame", {24'd0, fbits[8:1]}, 32'hFFFF_FFFF);
        else chk("frame_byte", {24'd0, fbits[8:1]}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Called at a negedge with valid already meaningful; returns at the negedge
  // after the accepting edge, reporting that edge's cycle index.
  task automatic send(input logic [7:0] d, output int unsigned acc);
    int unsigned n = 0;
    data  = d;
    valid = 1'b1;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      acc = 0;
    end else begin
      sb.push_back(d);
      acc = cyc + 1;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_low(output int unsigned at);
    int unsigned n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 0);
    at = cyc;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((busy || in_frame || sb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, busy || in_frame}, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int unsigned acc[6];
    int unsigned a;
    int unsigned t;
    int unsigned bad;
    int unsigned base;
    int unsigned e1;
    int unsigned fr0;

    repeat (3) @(negedge clk);
    chk("rst_dout", {31'd0, dout}, 1);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dout !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("idle_line", bad, 0);

    // Single frame of 0x55
    base = starts.size();
    send(8'h55, a);
    valid = 1'b0;
    chk("busy_after_push", {31'd0, busy}, 1);
    wait_busy_low(t);
    chk("single_busy_fall", t - a, 161);
    chk("single_start", starts[base], a + 1);
    chk("single_frames", starts.size() - base, 1);
    wait_drain();

    // Burst of 0x01..0x06 with valid held high
    base = starts.size();
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), acc[i]);
      if (i == 4) chk("burst_full_ready", {31'd0, ready}, 0);
    end
    valid = 1'b0;
    for (int i = 1; i < 5; i++) chk("burst_accept", acc[i], acc[0] + i);
    chk("burst_accept6", acc[5], acc[0] + 162);
    wait_busy_low(t);
    chk("burst_busy_fall", t, acc[0] + 1 + 6 * FRAME);
    wait_drain();
    chk("burst_frames", starts.size() - base, 6);
    for (int i = 1; i < 6; i++)
      if (base + i < starts.size())
        chk("burst_contig", starts[base + i] - starts[base + i - 1], FRAME);

    // Backpressure: toggle data while the FIFO is full
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), a);
    data  = 8'h00;
    valid = 1'b1;
    chk("bp_full", {31'd0, ready}, 0);
    t = 0;
    while (!ready && t < 400) begin
      data = 8'($urandom_range(0, 255));
      @(negedge clk);
      t++;
    end
    data = 8'hC3;
    send(8'hC3, a);
    valid = 1'b0;
    data  = 8'h3C;
    wait_drain();

    // Reset during bit 3 of 0xA5 with two bytes queued
    send(8'hA5, a);
    e1 = a + 1;
    send(8'h01, a);
    send(8'h02, a);
    valid = 1'b0;
    while (cyc < e1 + 70) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout", {31'd0, dout}, 1);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ready", {31'd0, ready}, 1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fr0 = frames;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (dout !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_frames", frames, fr0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
